// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter and its serial id receiver.
package bus_pkg;

  localparam int SLAVE_LEN_DEF = 2;

  localparam logic OWNER_M1 = 1'b0;
  localparam logic OWNER_M2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RX_SELECT  = 3'd1,
    ST_GRANT      = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_TRANSFER   = 3'd4,
    ST_RELEASE    = 3'd5
  } state_e;

endpackage

// File: rtl/serial_id_rx.sv
// Serial LSB-first id receiver. A start pulse arms it, and the following SLAVE_LEN
// cycles each capture one bit. done/id are valid in the cycle that takes the last bit.
module serial_id_rx
  import bus_pkg::*;
#(
  parameter int SLAVE_LEN = SLAVE_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bit_in,
  output logic [SLAVE_LEN-1:0] id,
  output logic                 done
);

  localparam int CNT_W = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLAVE_LEN - 1);

  logic                 active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLAVE_LEN-1:0] shift_q, shift_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      shift_d  = '0;
    end else if (active_q) begin
      shift_d[cnt_q] = bit_in;
      if (cnt_q == LAST_BIT) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // id includes the bit being taken this cycle so the caller can act on the final edge.
  assign id   = shift_d;
  assign done = active_q && !start && (cnt_q == LAST_BIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin pick, serial slave id reception, one-cycle grant,
// ownership held until the owner completes or times out. All outputs are flops.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int SLAVE_LEN  = SLAVE_LEN_DEF,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_request,
  input  logic                  m1_slave_select,
  input  logic                  m1_master_valid,
  input  logic                  m1_master_ready,
  input  logic                  m2_request,
  input  logic                  m2_slave_select,
  input  logic                  m2_master_valid,
  input  logic                  m2_master_ready,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  arbitor_busy,
  output logic                  bus_busy,
  output logic                  bus_owner,
  output logic [NUM_SLAVES-1:0] slave_en,
  output logic                  sel_error,
  output logic [2:0]            state_dbg
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic                    arb_busy_q, arb_busy_d;
  logic                    bus_busy_q, bus_busy_d;
  logic                    m1_grant_q, m1_grant_d;
  logic                    m2_grant_q, m2_grant_d;
  logic [NUM_SLAVES-1:0]   slave_en_q, slave_en_d;
  logic                    sel_error_q, sel_error_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

  logic                    rx_start;
  logic                    rx_bit;
  logic [SLAVE_LEN-1:0]    rx_id;
  logic                    rx_done;
  logic                    winner;
  logic                    owner_valid;
  logic                    owner_ready;

  assign rx_bit      = (owner_q == OWNER_M2) ? m2_slave_select : m1_slave_select;
  assign owner_valid = (owner_q == OWNER_M2) ? m2_master_valid : m1_master_valid;
  assign owner_ready = (owner_q == OWNER_M2) ? m2_master_ready : m1_master_ready;

  serial_id_rx #(.SLAVE_LEN(SLAVE_LEN)) u_id_rx (
    .clk    (clk),
    .reset  (reset),
    .start  (rx_start),
    .bit_in (rx_bit),
    .id     (rx_id),
    .done   (rx_done)
  );

  // On a tie the master that did not own the bus last wins.
  always_comb begin
    if (m1_request && m2_request) winner = ~last_owner_q;
    else if (m2_request)          winner = OWNER_M2;
    else                          winner = OWNER_M1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_M1;
      last_owner_q <= OWNER_M2;
      arb_busy_q   <= 1'b0;
      bus_busy_q   <= 1'b0;
      m1_grant_q   <= 1'b0;
      m2_grant_q   <= 1'b0;
      slave_en_q   <= '0;
      sel_error_q  <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      arb_busy_q   <= arb_busy_d;
      bus_busy_q   <= bus_busy_d;
      m1_grant_q   <= m1_grant_d;
      m2_grant_q   <= m2_grant_d;
      slave_en_q   <= slave_en_d;
      sel_error_q  <= sel_error_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Each output flop is loaded with the value belonging to the state being entered.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    arb_busy_d   = 1'b0;
    bus_busy_d   = 1'b0;
    m1_grant_d   = 1'b0;
    m2_grant_d   = 1'b0;
    slave_en_d   = slave_en_q;
    sel_error_d  = 1'b0;
    to_cnt_d     = to_cnt_q;
    rx_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        slave_en_d = '0;
        if (m1_request || m2_request) begin
          owner_d    = winner;
          arb_busy_d = 1'b1;
          rx_start   = 1'b1;
          state_d    = ST_RX_SELECT;
        end
      end
      ST_RX_SELECT: begin
        arb_busy_d = 1'b1;
        if (rx_done) begin
          arb_busy_d = 1'b0;
          if (32'(rx_id) < NUM_SLAVES) begin
            m1_grant_d   = (owner_q == OWNER_M1);
            m2_grant_d   = (owner_q == OWNER_M2);
            bus_busy_d   = 1'b1;
            slave_en_d   = NUM_SLAVES'(1) << rx_id;
            last_owner_d = owner_q;
            state_d      = ST_GRANT;
          end else begin
            sel_error_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        bus_busy_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        bus_busy_d = 1'b1;
        to_cnt_d   = to_cnt_q + TO_W'(1);
        if (owner_valid) begin
          state_d = ST_TRANSFER;
        end else if (to_cnt_q == TO_LAST) begin
          sel_error_d = 1'b1;
          bus_busy_d  = 1'b0;
          slave_en_d  = '0;
          state_d     = ST_RELEASE;
        end
      end
      ST_TRANSFER: begin
        bus_busy_d = 1'b1;
        if (owner_ready) begin
          bus_busy_d = 1'b0;
          slave_en_d = '0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        slave_en_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        slave_en_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  assign m1_grant     = m1_grant_q;
  assign m2_grant     = m2_grant_q;
  assign arbitor_busy = arb_busy_q;
  assign bus_busy     = bus_busy_q;
  assign bus_owner    = owner_q;
  assign slave_en     = slave_en_q;
  assign sel_error    = sel_error_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant scoreboard plus cycle-exact output checks.
module tb_bus_arbiter;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_request, m1_slave_select, m1_master_valid, m1_master_ready;
  logic       m2_request, m2_slave_select, m2_master_valid, m2_master_ready;
  logic       m1_grant, m2_grant, arbitor_busy, bus_busy, bus_owner, sel_error;
  logic [2:0] slave_en;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_obs, mon_exp;

  always #5 clk = ~clk;

  bus_arbiter #(.SLAVE_LEN(2), .NUM_SLAVES(3), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .m1_request      (m1_request),
    .m1_slave_select (m1_slave_select),
    .m1_master_valid (m1_master_valid),
    .m1_master_ready (m1_master_ready),
    .m2_request      (m2_request),
    .m2_slave_select (m2_slave_select),
    .m2_master_valid (m2_master_valid),
    .m2_master_ready (m2_master_ready),
    .m1_grant        (m1_grant),
    .m2_grant        (m2_grant),
    .arbitor_busy    (arbitor_busy),
    .bus_busy        (bus_busy),
    .bus_owner       (bus_owner),
    .slave_en        (slave_en),
    .sel_error       (sel_error),
    .state_dbg       (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected grant record: {m1_grant, m2_grant, bus_owner, slave_en}
  task automatic push_grant(input logic who, input logic [1:0] id);
    logic [2:0] en;
    en = 3'b001 << id;
    exp_q.push_back({~who, who, who, en});
  endtask

  task automatic send_id(input logic who, input logic [1:0] id);
    if (who) m2_slave_select = id[0]; else m1_slave_select = id[0];
    step(1);
    if (who) m2_slave_select = id[1]; else m1_slave_select = id[1];
    step(1);
  endtask

  // Starts in the grant cycle, ends in the RELEASE cycle.
  task automatic finish_xfer(input logic who);
    step(1);
    check("wait_state", state_dbg, 3);
    check("wait_bus_busy", bus_busy, 1);
    if (who) m2_master_valid = 1'b1; else m1_master_valid = 1'b1;
    step(1);
    check("xfer_state", state_dbg, 4);
    if (who) begin m2_master_valid = 1'b0; m2_master_ready = 1'b1; end
    else     begin m1_master_valid = 1'b0; m1_master_ready = 1'b1; end
    step(1);
    check("release_state", state_dbg, 5);
    check("release_bus_busy", bus_busy, 0);
    check("release_slave_en", slave_en, 0);
    m1_master_ready = 1'b0;
    m2_master_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_dbg, 0);
    check({tag, "_grants"}, {m1_grant, m2_grant}, 0);
    check({tag, "_arb_busy"}, arbitor_busy, 0);
    check({tag, "_bus_busy"}, bus_busy, 0);
    check({tag, "_owner"}, bus_owner, 0);
    check({tag, "_slave_en"}, slave_en, 0);
    check({tag, "_sel_error"}, sel_error, 0);
  endtask

  // Every grant pulse must match the next expected record and never overlap arbitor_busy.
  always @(negedge clk) begin
    if (!reset && (m1_grant || m2_grant)) begin
      mon_obs = {m1_grant, m2_grant, bus_owner, slave_en};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_grant observed=%0h expected=none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (mon_obs === mon_exp) else begin
          fails++;
          $error("FAIL grant_record observed=%0h expected=%0h", mon_obs, mon_exp);
        end
      end
      tests++;
      assert (arbitor_busy === 1'b0) else begin
        fails++;
        $error("FAIL grant_with_arb_busy observed=%0b expected=0", arbitor_busy);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {m1_request, m1_slave_select, m1_master_valid, m1_master_ready} = '0;
    {m2_request, m2_slave_select, m2_master_valid, m2_master_ready} = '0;
    step(2);
    check_reset_outputs("por");
    reset = 1'b0;
    step(1);

    // M1 alone, id 2
    push_grant(1'b0, 2'd2);
    m1_request = 1'b1;
    step(1);
    check("t1_arb_busy_c1", arbitor_busy, 1);
    check("t1_owner", bus_owner, 0);
    m1_request = 1'b0;
    m1_slave_select = 1'b0;
    step(1);
    check("t1_arb_busy_c2", arbitor_busy, 1);
    m1_slave_select = 1'b1;
    step(1);
    check("t1_arb_busy_off", arbitor_busy, 0);
    check("t1_m1_grant", m1_grant, 1);
    check("t1_slave_en", slave_en, 3'b100);
    check("t1_bus_busy", bus_busy, 1);
    finish_xfer(1'b0);
    step(1);
    check("t1_idle", state_dbg, 0);

    // Tie after reset goes to M1, then strict alternation
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push_grant(1'b0, 2'd1);
    push_grant(1'b1, 2'd0);
    m1_request = 1'b1;
    m2_request = 1'b1;
    step(1);
    check("t2_tie_owner", bus_owner, 0);
    m1_request = 1'b0;
    send_id(1'b0, 2'd1);
    check("t2_m1_grant", m1_grant, 1);
    finish_xfer(1'b0);
    step(2);
    check("t2_second_owner", bus_owner, 1);
    m2_request = 1'b0;
    send_id(1'b1, 2'd0);
    check("t2_m2_grant", m2_grant, 1);
    finish_xfer(1'b1);
    step(1);
    push_grant(1'b0, 2'd2);
    push_grant(1'b1, 2'd1);
    m1_request = 1'b1;
    m2_request = 1'b1;
    step(1);
    check("t2_rr_owner_m1", bus_owner, 0);
    m1_request = 1'b0;
    send_id(1'b0, 2'd2);
    finish_xfer(1'b0);
    step(2);
    check("t2_rr_owner_m2", bus_owner, 1);
    m2_request = 1'b0;
    send_id(1'b1, 2'd1);
    finish_xfer(1'b1);
    step(1);

    // Rejected id from M2
    m2_request = 1'b1;
    step(1);
    check("t3_owner", bus_owner, 1);
    m2_request = 1'b0;
    send_id(1'b1, 2'd3);
    check("t3_sel_error", sel_error, 1);
    check("t3_no_grant", {m1_grant, m2_grant}, 0);
    check("t3_idle", state_dbg, 0);
    check("t3_bus_busy", bus_busy, 0);
    step(1);
    check("t3_sel_error_pulse", sel_error, 0);
    push_grant(1'b0, 2'd1);
    m1_request = 1'b1;
    step(1);
    m1_request = 1'b0;
    send_id(1'b0, 2'd1);
    check("t3_m1_grant", m1_grant, 1);
    finish_xfer(1'b0);
    step(1);

    // Timeout when M1 never raises master_valid
    push_grant(1'b0, 2'd0);
    m1_request = 1'b1;
    step(1);
    m1_request = 1'b0;
    send_id(1'b0, 2'd0);
    check("t4_grant", m1_grant, 1);
    step(16);
    check("t4_still_wait", state_dbg, 3);
    check("t4_busy_before", bus_busy, 1);
    check("t4_no_err_early", sel_error, 0);
    check("t4_slave_en_held", slave_en, 3'b001);
    step(1);
    check("t4_sel_error", sel_error, 1);
    check("t4_bus_busy", bus_busy, 0);
    check("t4_slave_en", slave_en, 0);
    check("t4_release", state_dbg, 5);
    step(1);
    check("t4_err_pulse", sel_error, 0);

    // M2 request held off during M1 transfer
    push_grant(1'b0, 2'd2);
    push_grant(1'b1, 2'd1);
    m1_request = 1'b1;
    step(1);
    m1_request = 1'b0;
    send_id(1'b0, 2'd2);
    step(1);
    m1_master_valid = 1'b1;
    step(1);
    m1_master_valid = 1'b0;
    m2_request = 1'b1;
    step(3);
    check("t5_xfer_held", state_dbg, 4);
    check("t5_bus_busy", bus_busy, 1);
    check("t5_arb_idle", arbitor_busy, 0);
    m1_master_ready = 1'b1;
    step(1);
    check("t5_release", state_dbg, 5);
    m1_master_ready = 1'b0;
    step(1);
    check("t5_idle", state_dbg, 0);
    step(1);
    check("t5_m2_owner", bus_owner, 1);
    check("t5_arb_busy", arbitor_busy, 1);
    m2_request = 1'b0;
    send_id(1'b1, 2'd1);
    check("t5_m2_grant", m2_grant, 1);
    finish_xfer(1'b1);
    step(1);

    // Asynchronous reset during RX_SELECT and during TRANSFER
    m1_request = 1'b1;
    step(1);
    m1_request = 1'b0;
    check("t6_in_rx", state_dbg, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_rx");
    reset = 1'b0;
    step(1);
    push_grant(1'b1, 2'd0);
    m2_request = 1'b1;
    step(1);
    m2_request = 1'b0;
    send_id(1'b1, 2'd0);
    step(1);
    m2_master_valid = 1'b1;
    step(1);
    m2_master_valid = 1'b0;
    check("t6_in_xfer", state_dbg, 4);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_xfer");
    reset = 1'b0;
    step(2);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
